// File: rtl/falafel_pkg.sv
// ==== falafel_pkg: shared types for the falafel allocator request path. Rev 1.0 ====
`default_nettype none

package falafel_pkg;

  localparam int DATA_W      = 64;
  localparam int MSG_ID_SIZE = 8;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 4;
  localparam int ID_LSB     = OPCODE_LSB + OPCODE_W;
  localparam int ID_W       = MSG_ID_SIZE;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ALLOC  = 4'd1,
    OP_FREE   = 4'd2,
    OP_CONFIG = 4'd3
  } opcode_e;

  typedef struct packed {
    logic [DATA_W-1:0]      size;
    logic [MSG_ID_SIZE-1:0] id;
  } alloc_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAY0 = 2'd1,
    PAY1 = 2'd2,
    EMIT = 2'd3
  } parser_state_e;

endpackage

`default_nettype wire

// File: rtl/falafel_header_parser.sv
// ==== falafel_header_parser: header-tagged word stream to alloc/free/config requests. Rev 1.0 ====
`default_nettype none

module falafel_header_parser
  import falafel_pkg::*;
#(
  parameter int DATA_W      = falafel_pkg::DATA_W,
  parameter int MSG_ID_SIZE = falafel_pkg::MSG_ID_SIZE
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               req_val_i,
  output logic               req_rdy_o,
  input  logic [DATA_W-1:0]  req_data_i,

  output logic               alloc_req_val_o,
  input  logic               alloc_req_rdy_i,
  output alloc_entry_t       alloc_req_data_o,

  output logic               free_req_val_o,
  input  logic               free_req_rdy_i,
  output alloc_entry_t       free_req_data_o,

  output logic               config_reg_write_o,
  output logic [DATA_W-1:0]  config_reg_addr_o,
  output logic [DATA_W-1:0]  config_reg_data_o,

  output logic               bad_opcode_o
);

  parser_state_e          state_q;
  logic [OPCODE_W-1:0]    opcode_q;
  logic [MSG_ID_SIZE-1:0] id_q;
  logic [DATA_W-1:0]      size_q;
  logic                   alloc_val_q;
  logic                   free_val_q;
  logic                   cfg_wr_q;
  logic [DATA_W-1:0]      cfg_addr_q;
  logic [DATA_W-1:0]      cfg_data_q;
  logic                   bad_q;

  logic                   req_fire;
  logic [OPCODE_W-1:0]    hdr_opcode;
  logic [MSG_ID_SIZE-1:0] hdr_id;
  logic                   emit_done;

  assign req_rdy_o  = (state_q != EMIT);
  assign req_fire   = req_val_i && req_rdy_o;
  assign hdr_opcode = req_data_i[OPCODE_LSB +: OPCODE_W];
  assign hdr_id     = req_data_i[ID_LSB +: MSG_ID_SIZE];
  // Only the handshake of the port actually carrying the request counts.
  assign emit_done  = (alloc_val_q && alloc_req_rdy_i) || (free_val_q && free_req_rdy_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      id_q        <= '0;
      size_q      <= '0;
      alloc_val_q <= 1'b0;
      free_val_q  <= 1'b0;
      cfg_wr_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      bad_q       <= 1'b0;
    end else begin
      cfg_wr_q <= 1'b0;
      bad_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_fire) begin
            opcode_q <= hdr_opcode;
            id_q     <= hdr_id;
            if (hdr_opcode == OP_ALLOC || hdr_opcode == OP_FREE ||
                hdr_opcode == OP_CONFIG) begin
              state_q <= PAY0;
            end else begin
              bad_q <= 1'b1;
            end
          end
        end
        PAY0: begin
          if (req_fire) begin
            if (opcode_q == OP_CONFIG) begin
              cfg_addr_q <= req_data_i;
              state_q    <= PAY1;
            end else begin
              size_q      <= req_data_i;
              alloc_val_q <= (opcode_q == OP_ALLOC);
              free_val_q  <= (opcode_q == OP_FREE);
              state_q     <= EMIT;
            end
          end
        end
        PAY1: begin
          if (req_fire) begin
            cfg_data_q <= req_data_i;
            cfg_wr_q   <= 1'b1;
            state_q    <= IDLE;
          end
        end
        EMIT: begin
          if (emit_done) begin
            alloc_val_q <= 1'b0;
            free_val_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alloc_req_val_o       = alloc_val_q;
  assign alloc_req_data_o.size = size_q;
  assign alloc_req_data_o.id   = id_q;
  assign free_req_val_o        = free_val_q;
  assign free_req_data_o.size  = size_q;
  assign free_req_data_o.id    = id_q;
  assign config_reg_write_o    = cfg_wr_q;
  assign config_reg_addr_o     = cfg_addr_q;
  assign config_reg_data_o     = cfg_data_q;
  assign bad_opcode_o          = bad_q;

endmodule

`default_nettype wire
